// File: rtl/b_channel.sv
// AXI write-response stage: tracks issued write addresses in order,
// retires them on B handshakes, and flags read/write address hazards.
module b_channel #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_issue,
  input  logic [31:0]      wr_issue_addr,
  output logic             wr_full,
  output logic [PTR_W:0]   wr_pending,
  input  logic [3:0]       bid,
  input  logic [1:0]       bresp,
  input  logic             bvalid,
  output logic             bready,
  output logic             data_sram_data_ok,
  output logic             bresp_err,
  input  logic [31:0]      rd_check_addr,
  output logic             rd_hazard
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0][29:0] addr_q, addr_d;
  logic [DEPTH-1:0]       vld_q, vld_d;
  logic [PTR_W-1:0]       wp_q, wp_d;
  logic [PTR_W-1:0]       rp_q, rp_d;
  logic [PTR_W:0]         cnt_q, cnt_d;
  logic                   ok_q, ok_d;
  logic                   err_q, err_d;

  logic push;
  logic pop;

  // response ID and byte offsets play no part in in-order matching
  logic unused_bits;
  assign unused_bits = ^{bid, wr_issue_addr[1:0], rd_check_addr[1:0]};

  assign wr_full           = (cnt_q == FULL_CNT);
  assign wr_pending        = cnt_q;
  assign bready            = (cnt_q != '0);
  assign data_sram_data_ok = ok_q;
  assign bresp_err         = err_q;

  assign push = wr_issue && !wr_full;
  assign pop  = bvalid && bready;

  always_comb begin
    addr_d = addr_q;
    vld_d  = vld_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    cnt_d  = cnt_q;
    ok_d   = pop;
    err_d  = err_q || (pop && (bresp != 2'b00));
    if (pop) begin
      vld_d[rp_q] = 1'b0;
      rp_d        = rp_q + 1'b1;
    end
    if (push) begin
      addr_d[wp_q] = wr_issue_addr[31:2];
      vld_d[wp_q]  = 1'b1;
      wp_d         = wp_q + 1'b1;
    end
    unique case (1'b1)
      push && !pop: cnt_d = cnt_q + 1'b1;
      pop && !push: cnt_d = cnt_q - 1'b1;
      default:      cnt_d = cnt_q;
    endcase
  end

  // table state only: a same-cycle push is not yet visible here
  always_comb begin
    rd_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i] == rd_check_addr[31:2])) begin
        rd_hazard = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      vld_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      vld_q  <= vld_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      ok_q   <= ok_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_b_channel.sv
// Bench for b_channel: directed scenarios plus random traffic against
// an in-order queue model, with a decoupled completion scoreboard.
module tb_b_channel;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_issue;
  logic [31:0]      wr_issue_addr;
  logic             wr_full;
  logic [PTR_W:0]   wr_pending;
  logic [3:0]       bid;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready;
  logic             data_sram_data_ok;
  logic             bresp_err;
  logic [31:0]      rd_check_addr;
  logic             rd_hazard;

  b_channel #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .wr_issue          (wr_issue),
    .wr_issue_addr     (wr_issue_addr),
    .wr_full           (wr_full),
    .wr_pending        (wr_pending),
    .bid               (bid),
    .bresp             (bresp),
    .bvalid            (bvalid),
    .bready            (bready),
    .data_sram_data_ok (data_sram_data_ok),
    .bresp_err         (bresp_err),
    .rd_check_addr     (rd_check_addr),
    .rd_hazard         (rd_hazard)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   due;
    logic err;
  } done_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [29:0] model_q[$];
  done_t       exp_q[$];
  logic        model_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic model_hazard(input logic [31:0] a);
    foreach (model_q[i]) if (model_q[i] == a[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  // completion monitor: one pulse per handshake, exactly one cycle later
  always @(negedge clk) begin
    if (reset) begin
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        check("data_ok_pulse", 32'(data_sram_data_ok), 32'd1);
        check("data_ok_err", 32'(bresp_err), 32'(exp_q[0].err));
        void'(exp_q.pop_front());
      end else if (data_sram_data_ok) begin
        check("data_ok_spurious", 32'(data_sram_data_ok), 32'd0);
      end
    end
  end

  task automatic step(input logic iss, input logic [31:0] a,
                      input logic bv, input logic [1:0] br,
                      input logic [31:0] chk_a);
    logic do_push, do_pop;
    @(negedge clk);
    wr_issue      = iss;
    wr_issue_addr = a;
    bvalid        = bv;
    bresp         = br;
    bid           = 4'($urandom_range(0, 15));
    rd_check_addr = chk_a;
    #1;
    check("bready", 32'(bready), 32'(model_q.size() != 0));
    check("wr_full", 32'(wr_full), 32'(model_q.size() == DEPTH));
    check("wr_pending", 32'(wr_pending), 32'(model_q.size()));
    check("rd_hazard", 32'(rd_hazard), 32'(model_hazard(chk_a)));
    check("bresp_err", 32'(bresp_err), 32'(model_err));
    do_pop  = bv && (model_q.size() != 0);
    do_push = iss && (model_q.size() < DEPTH);
    if (do_pop) begin
      model_err = model_err | (br != 2'b00);
      exp_q.push_back('{due: cyc + 1, err: model_err});
      void'(model_q.pop_front());
    end
    if (do_push) model_q.push_back(a[31:2]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
  endtask

  task automatic reset_mid_flight(input logic [31:0] probe);
    @(negedge clk);
    wr_issue      = 1'b0;
    bvalid        = 1'b1;
    bresp         = 2'b00;
    rd_check_addr = probe;
    #1;
    check("rst_pre_bready", 32'(bready), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    model_q.delete();
    exp_q.delete();
    model_err = 1'b0;
    check("rst_bready", 32'(bready), 32'd0);
    check("rst_wr_full", 32'(wr_full), 32'd0);
    check("rst_pending", 32'(wr_pending), 32'd0);
    check("rst_data_ok", 32'(data_sram_data_ok), 32'd0);
    check("rst_bresp_err", 32'(bresp_err), 32'd0);
    check("rst_hazard", 32'(rd_hazard), 32'd0);
    @(negedge clk);
    check("rst_no_pulse", 32'(data_sram_data_ok), 32'd0);
    bvalid = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'h8000_0000 | (32'($urandom_range(0, 7)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    reset         = 1'b0;
    wr_issue      = 1'b0;
    wr_issue_addr = '0;
    bid           = '0;
    bresp         = '0;
    bvalid        = 1'b0;
    rd_check_addr = '0;
    #3;
    check("init_bready", 32'(bready), 32'd0);
    check("init_wr_full", 32'(wr_full), 32'd0);
    check("init_pending", 32'(wr_pending), 32'd0);
    check("init_data_ok", 32'(data_sram_data_ok), 32'd0);
    check("init_bresp_err", 32'(bresp_err), 32'd0);
    check("init_hazard", 32'(rd_hazard), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;

    // single write
    step(1'b1, 32'h1000_0004, 1'b0, 2'b00, 32'h1000_0004);
    step(1'b0, 32'h0, 1'b1, 2'b00, 32'h1000_0004);
    idle(2);

    // fill, overflow attempt, drain
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h2000_0000 + 32'(i * 4), 1'b0, 2'b00, 32'h0);
    step(1'b1, 32'h2000_0100, 1'b0, 2'b00, 32'h2000_0100);
    step(1'b0, 32'h0, 1'b0, 2'b00, 32'h2000_0100);
    for (int i = 0; i < 4; i++)
      step(1'b0, 32'h0, 1'b1, 2'b00, 32'h2000_000c);
    idle(2);

    // three outstanding, then push+pop across the pointer wrap
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h3000_0000 + 32'(i * 4), 1'b0, 2'b00, 32'h0);
    step(1'b1, 32'h3000_0040, 1'b1, 2'b00, 32'h3000_0040);
    step(1'b0, 32'h0, 1'b0, 2'b00, 32'h3000_0040);
    step(1'b0, 32'h0, 1'b0, 2'b00, 32'h3000_0000);
    for (int i = 0; i < 3; i++)
      step(1'b0, 32'h0, 1'b1, 2'b00, 32'h3000_0040);
    idle(1);

    // hazard
    step(1'b1, 32'h8000_0010, 1'b0, 2'b00, 32'h8000_0010);
    step(1'b0, 32'h0, 1'b0, 2'b00, 32'h8000_0013);
    step(1'b0, 32'h0, 1'b0, 2'b00, 32'h8000_0014);
    step(1'b0, 32'h0, 1'b1, 2'b00, 32'h8000_0010);
    step(1'b0, 32'h0, 1'b0, 2'b00, 32'h8000_0010);

    // error response, sticky through later OKAYs
    step(1'b1, 32'h4000_0000, 1'b0, 2'b00, 32'h0);
    step(1'b1, 32'h4000_0004, 1'b1, 2'b10, 32'h0);
    step(1'b0, 32'h0, 1'b1, 2'b00, 32'h0);
    idle(2);

    // reset with two outstanding and a handshake in the same cycle
    step(1'b1, 32'h5000_0000, 1'b0, 2'b00, 32'h0);
    step(1'b1, 32'h5000_0004, 1'b0, 2'b00, 32'h0);
    reset_mid_flight(32'h5000_0004);
    idle(2);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), rnd_addr(),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3) == 0 ? 2 : 0),
           rnd_addr());

    for (int i = 0; i < DEPTH + 2; i++)
      step(1'b0, 32'h0, 1'b1, 2'b00, rnd_addr());
    idle(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
